// File: rtl/psg_mix_pkg.sv
// Shared definitions for the PSG stereo mixer: routing mode codes, fade FSM
// states and a constant-evaluable clog2.
package psg_mix_pkg;

  localparam logic [1:0] MODE_MONO   = 2'd0;
  localparam logic [1:0] MODE_ABC    = 2'd1;
  localparam logic [1:0] MODE_ACB    = 2'd2;
  localparam logic [1:0] MODE_CUSTOM = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FADE_OUT,
    ST_SWITCH,
    ST_FADE_IN
  } fade_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psg_sd_dac.sv
// First-order sigma-delta modulator: the carry out of a W-bit phase
// accumulator gives a 1-bit stream whose duty is pcm_i / 2^W.
module psg_sd_dac
  import psg_mix_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk_sys,
  input  logic         res_n,
  input  logic [W-1:0] pcm_i,
  output logic         dac_o
);

  logic [W-1:0] acc_q, acc_d;
  logic         dac_q, dac_d;

  assign {dac_d, acc_d} = {1'b0, acc_q} + {1'b0, pcm_i};

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      acc_q <= '0;
      dac_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      dac_q <= dac_d;
    end
  end

  assign dac_o = dac_q;

endmodule

// File: rtl/psg_stereo_mix.sv
// PSG stereo mixer: routes NCH unsigned channels to L/R, applies a fade gain
// and drives two sigma-delta DACs. Optional fade FSM: PSG_STEREO_MIX_FADE_EN.
module psg_stereo_mix
  import psg_mix_pkg::*;
#(
  parameter  int NCH        = 3,
  parameter  int IW         = 8,
  parameter  int FADE_STEPS = 16,
  localparam int OW         = IW + clog2(NCH),
  localparam int GSH        = clog2(FADE_STEPS),
  localparam int GW         = GSH + 1
) (
  input  logic              clk_sys,
  input  logic              res_n,
  input  logic              ce_sample,
  input  logic [NCH*IW-1:0] ch_in,
  input  logic [1:0]        mode,
  input  logic [NCH-1:0]    pan_l,
  input  logic [NCH-1:0]    pan_r,
  output logic [OW-1:0]     pcm_l,
  output logic [OW-1:0]     pcm_r,
  output logic              pcm_valid,
  output logic              dac_l,
  output logic              dac_r,
  output logic              busy
);

  logic [NCH*IW-1:0] ch_p0;
  logic [NCH-1:0]    pan_l_p0, pan_r_p0;
  logic              vld_p0, vld_p1, vld_p2;
  logic [NCH-1:0]    mask_l, mask_r;
  logic [OW-1:0]     sum_l_d, sum_r_d;
  logic [OW-1:0]     sum_l_p1, sum_r_p1;
  logic [OW-1:0]     pcm_l_q, pcm_r_q;
  logic [1:0]        act_mode;
  logic [GW-1:0]     gain;

  function automatic logic [OW-1:0] apply_gain(input logic [OW-1:0] s,
                                               input logic [GW-1:0] g);
    return OW'(({{GW{1'b0}}, s} * {{OW{1'b0}}, g}) >> GSH);
  endfunction

  // ACB swaps channels 1 and NCH-1 before the ABC half/half rule is applied.
  function automatic logic [NCH-1:0] side_mask(input logic [1:0]     md,
                                               input logic [NCH-1:0] pan,
                                               input logic           right);
    logic [NCH-1:0] m;
    int             pos;
    m = '0;
    for (int i = 0; i < NCH; i++) begin
      pos = i;
      if (md == MODE_ACB) begin
        if (i == 1)            pos = NCH - 1;
        else if (i == NCH - 1) pos = 1;
      end
      case (md)
        MODE_MONO:   m[i] = 1'b1;
        MODE_CUSTOM: m[i] = pan[i];
        default:     m[i] = right ? (pos >= NCH / 2) : (pos <= (NCH - 1) / 2);
      endcase
    end
    return m;
  endfunction

  // Stage 0: capture the sample frame on the strobe
  always_ff @(posedge clk_sys) begin
    if (ce_sample) begin
      ch_p0    <= ch_in;
      pan_l_p0 <= pan_l;
      pan_r_p0 <= pan_r;
    end
  end

  always_comb begin
    mask_l  = side_mask(act_mode, pan_l_p0, 1'b0);
    mask_r  = side_mask(act_mode, pan_r_p0, 1'b1);
    sum_l_d = '0;
    sum_r_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (mask_l[i]) sum_l_d = sum_l_d + OW'(ch_p0[i*IW +: IW]);
      if (mask_r[i]) sum_r_d = sum_r_d + OW'(ch_p0[i*IW +: IW]);
    end
  end

  // Stage 1: routed sums
  always_ff @(posedge clk_sys) begin
    if (vld_p0) begin
      sum_l_p1 <= sum_l_d;
      sum_r_p1 <= sum_r_d;
    end
  end

  // Stage 2: gain-scaled PCM, held between frames
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      pcm_l_q <= '0;
      pcm_r_q <= '0;
    end else begin
      vld_p0 <= ce_sample;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        pcm_l_q <= apply_gain(sum_l_p1, gain);
        pcm_r_q <= apply_gain(sum_r_p1, gain);
      end
    end
  end

`ifdef PSG_STEREO_MIX_FADE_EN
  fade_state_e   state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [1:0]    act_mode_q, act_mode_d;

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state_q    <= ST_RUN;
      g_q        <= GW'(FADE_STEPS);
      act_mode_q <= MODE_MONO;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      act_mode_q <= act_mode_d;
    end
  end

  // The mode sampled on the strobe is compared directly, so a change starts
  // fading on the same strobe that delivers it.
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    act_mode_d = act_mode_q;
    if (ce_sample) begin
      unique case (state_q)
        ST_RUN: begin
          if (mode != act_mode_q) state_d = ST_FADE_OUT;
        end
        ST_FADE_OUT: begin
          g_d = g_q - GW'(1);
          if (mode == act_mode_q)  state_d = ST_FADE_IN;
          else if (g_q == GW'(1))  state_d = ST_SWITCH;
        end
        ST_SWITCH: begin
          act_mode_d = mode;
          state_d    = ST_FADE_IN;
        end
        ST_FADE_IN: begin
          g_d = g_q + GW'(1);
          if (mode != act_mode_q)                 state_d = ST_FADE_OUT;
          else if (g_q == GW'(FADE_STEPS - 1))    state_d = ST_RUN;
        end
      endcase
    end
  end

  assign act_mode = act_mode_q;
  assign gain     = g_q;
  assign busy     = (state_q != ST_RUN);
`else
  logic [1:0] mode_p0;

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n)         mode_p0 <= MODE_MONO;
    else if (ce_sample) mode_p0 <= mode;
  end

  assign act_mode = mode_p0;
  assign gain     = GW'(FADE_STEPS);
  assign busy     = 1'b0;
`endif

  psg_sd_dac #(.W(OW)) u_dac_l (
    .clk_sys (clk_sys),
    .res_n   (res_n),
    .pcm_i   (pcm_l_q),
    .dac_o   (dac_l)
  );

  psg_sd_dac #(.W(OW)) u_dac_r (
    .clk_sys (clk_sys),
    .res_n   (res_n),
    .pcm_i   (pcm_r_q),
    .dac_o   (dac_r)
  );

  assign pcm_l     = pcm_l_q;
  assign pcm_r     = pcm_r_q;
  assign pcm_valid = vld_p2;

endmodule

// File: tb/tb_psg_stereo_mix.sv
// Scoreboard bench for psg_stereo_mix (NCH=3, IW=8, FADE_STEPS=16); fade
// scenarios are built when PSG_STEREO_MIX_FADE_EN is defined.
module tb_psg_stereo_mix;

  localparam int NCH = 3;
  localparam int IW  = 8;
  localparam int OW  = 10;
  localparam int CW  = NCH * IW;

  logic           clk_sys   = 1'b0;
  logic           res_n     = 1'b0;
  logic           ce_sample = 1'b0;
  logic [CW-1:0]  ch_in     = '0;
  logic [1:0]     mode      = 2'd0;
  logic [NCH-1:0] pan_l     = '0;
  logic [NCH-1:0] pan_r     = '0;
  logic [OW-1:0]  pcm_l, pcm_r;
  logic           pcm_valid, dac_l, dac_r, busy;

  typedef struct {
    logic [OW-1:0] l;
    logic [OW-1:0] r;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   errors       = 0;
  int   checks       = 0;
  int   cyc          = 0;
  int   busy_strobes = 0;

  psg_stereo_mix #(.NCH(NCH), .IW(IW), .FADE_STEPS(16)) dut (
    .clk_sys   (clk_sys),
    .res_n     (res_n),
    .ce_sample (ce_sample),
    .ch_in     (ch_in),
    .mode      (mode),
    .pan_l     (pan_l),
    .pan_r     (pan_r),
    .pcm_l     (pcm_l),
    .pcm_r     (pcm_r),
    .pcm_valid (pcm_valid),
    .dac_l     (dac_l),
    .dac_r     (dac_r),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse consumes one expected frame.
  always @(negedge clk_sys) begin
    if (res_n && pcm_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pcm_l=%0d pcm_r=%0d, expected no output", pcm_l, pcm_r);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pcm_l", int'(pcm_l), int'(e.l));
        chk("pcm_r", int'(pcm_r), int'(e.r));
        chk("valid_latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input int a, input int b, input int c, input logic [1:0] md,
                      input logic [NCH-1:0] pl, input logic [NCH-1:0] pr,
                      input int el, input int er);
    exp_t e;
    @(negedge clk_sys);
    if (busy) busy_strobes++;
    ch_in     = {IW'(c), IW'(b), IW'(a)};
    mode      = md;
    pan_l     = pl;
    pan_r     = pr;
    ce_sample = 1'b1;
    e.l   = OW'(el);
    e.r   = OW'(er);
    e.cyc = cyc + 3;
    sb.push_back(e);
    @(negedge clk_sys);
    ce_sample = 1'b0;
    ch_in     = CW'($urandom);
    mode      = 2'($urandom);
    pan_l     = NCH'($urandom);
    pan_r     = NCH'($urandom);
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic dac_count(input int el, input int er);
    int nl = 0;
    int nr = 0;
    repeat (1024) begin
      @(negedge clk_sys);
      if (dac_l) nl++;
      if (dac_r) nr++;
    end
    chk("dac_l_ones", nl, el);
    chk("dac_r_ones", nr, er);
  endtask

  task automatic pulse_reset();
    @(negedge clk_sys);
    #2 res_n = 1'b0;
    #1;
    chk("rst_pcm_l", int'(pcm_l), 0);
    chk("rst_pcm_r", int'(pcm_r), 0);
    chk("rst_valid", int'(pcm_valid), 0);
    chk("rst_dac_l", int'(dac_l), 0);
    chk("rst_dac_r", int'(dac_r), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk_sys);
    res_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    chk("init_pcm_l", int'(pcm_l), 0);
    chk("init_pcm_r", int'(pcm_r), 0);
    chk("init_valid", int'(pcm_valid), 0);
    chk("init_dac_l", int'(dac_l), 0);
    chk("init_dac_r", int'(dac_r), 0);
    chk("init_busy", int'(busy), 0);
    res_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    send(100, 50, 10, 2'd0, 3'b000, 3'b000, 160, 160);
    send(255, 255, 255, 2'd0, 3'b000, 3'b000, 765, 765);
    send(255, 255, 2, 2'd0, 3'b000, 3'b000, 512, 512);
    dac_count(512, 512);

`ifdef PSG_STEREO_MIX_FADE_EN
    // Mono -> ABC with full fade out / switch / fade in
    send(64, 64, 64, 2'd0, 3'b000, 3'b000, 192, 192);
    busy_strobes = 0;
    send(64, 64, 64, 2'd1, 3'b000, 3'b000, 192, 192);
    for (int g = 15; g >= 0; g--) send(64, 64, 64, 2'd1, 3'b000, 3'b000, 12 * g, 12 * g);
    send(64, 64, 64, 2'd1, 3'b000, 3'b000, 0, 0);
    for (int g = 1; g <= 16; g++) send(64, 64, 64, 2'd1, 3'b000, 3'b000, 8 * g, 8 * g);
    send(64, 64, 64, 2'd1, 3'b000, 3'b000, 128, 128);
    chk("busy_strobes", busy_strobes, 33);
    chk("busy_after_fade", int'(busy), 0);

    // ABC -> mono, reset during the fade-in
    send(64, 64, 64, 2'd0, 3'b000, 3'b000, 128, 128);
    for (int g = 15; g >= 0; g--) send(64, 64, 64, 2'd0, 3'b000, 3'b000, 8 * g, 8 * g);
    send(64, 64, 64, 2'd0, 3'b000, 3'b000, 0, 0);
    for (int g = 1; g <= 3; g++) send(64, 64, 64, 2'd0, 3'b000, 3'b000, 12 * g, 12 * g);
    chk("busy_mid_fade_in", int'(busy), 1);
    pulse_reset();
    send(64, 64, 64, 2'd0, 3'b000, 3'b000, 192, 192);
    chk("busy_after_reset", int'(busy), 0);

    // Aborted change: back to mono on the 5th fade-out strobe
    send(64, 64, 64, 2'd1, 3'b000, 3'b000, 192, 192);
    for (int g = 15; g >= 12; g--) send(64, 64, 64, 2'd1, 3'b000, 3'b000, 12 * g, 12 * g);
    send(64, 64, 64, 2'd0, 3'b000, 3'b000, 132, 132);
    for (int g = 12; g <= 16; g++) send(64, 64, 64, 2'd0, 3'b000, 3'b000, 12 * g, 12 * g);
    send(64, 64, 64, 2'd0, 3'b000, 3'b000, 192, 192);
    chk("busy_after_abort", int'(busy), 0);
`else
    send(100, 50, 10, 2'd1, 3'b000, 3'b000, 150, 60);
    send(100, 50, 10, 2'd2, 3'b000, 3'b000, 110, 60);
    send(100, 50, 10, 2'd3, 3'b001, 3'b110, 100, 60);
    send(100, 50, 10, 2'd3, 3'b101, 3'b011, 110, 150);
    send(100, 50, 10, 2'd3, 3'b111, 3'b000, 160, 0);
    send(200, 20, 3, 2'd1, 3'b000, 3'b000, 220, 23);
    send(200, 20, 3, 2'd2, 3'b000, 3'b000, 203, 23);
    send(100, 50, 10, 2'd3, 3'b001, 3'b010, 100, 50);
    dac_count(100, 50);
    chk("busy_tied_low", int'(busy), 0);
    pulse_reset();
    send(100, 50, 10, 2'd0, 3'b000, 3'b000, 160, 160);
`endif

    repeat (4) @(negedge clk_sys);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
